// File: rtl/snow64_decode_queue_pkg.sv
// Snow64 decode-queue types: instruction layouts, decoded record, queue entry.
// decode() turns one raw 32-bit word into the decoded record.
package snow64_decode_queue_pkg;

    localparam int WIDTH_ADDR  = 64;
    localparam int WIDTH_INSTR = 32;

    typedef enum logic [2:0] {
        GRP_IOG0 = 3'd0,
        GRP_IOG1 = 3'd1,
        GRP_IOG2 = 3'd2,
        GRP_IOG3 = 3'd3
    } group_t;

    typedef enum logic [3:0] {
        OP0_ADD  = 4'd0,
        OP0_SUB  = 4'd1,
        OP0_BAD0 = 4'd14,
        OP0_BAD1 = 4'd15
    } oper_iog0_t;

    typedef enum logic [3:0] {
        OP1_BTRU = 4'd0,
        OP1_BFAL = 4'd1,
        OP1_JMP  = 4'd2
    } oper_iog1_t;

    typedef enum logic [3:0] {
        OP2_LDF16 = 4'd8
    } oper_iog2_t;

    typedef enum logic [3:0] {
        OP3_STF16 = 4'd8
    } oper_iog3_t;

    typedef struct packed {
        logic [2:0]  group;
        logic        op_type;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rc;
        logic [3:0]  oper;
        logic [11:0] simm12;
    } iog0_instr_t;

    typedef struct packed {
        logic [2:0]  group;
        logic        op_type;
        logic [3:0]  ra;
        logic [3:0]  oper;
        logic [19:0] simm20;
    } iog1_instr_t;

    typedef iog0_instr_t iog2_instr_t;
    typedef iog0_instr_t iog3_instr_t;

    typedef struct packed {
        logic [2:0]            group;
        logic [3:0]            oper;
        logic                  op_type;
        logic [3:0]            ra;
        logic [3:0]            rb;
        logic [3:0]            rc;
        logic                  nop;
        logic [WIDTH_ADDR-1:0] signext_imm;
    } instr_decoder_out_t;

    typedef struct packed {
        instr_decoder_out_t    dec;
        logic [WIDTH_ADDR-1:0] pc;
    } queue_entry_t;

    function automatic instr_decoder_out_t decode(
        input logic [WIDTH_INSTR-1:0] word
    );
        iog0_instr_t        i0;
        iog1_instr_t        i1;
        instr_decoder_out_t d;
        logic [WIDTH_ADDR-1:0] imm12;
        logic [WIDTH_ADDR-1:0] imm20;
        i0    = word;
        i1    = word;
        imm12 = {{(WIDTH_ADDR-12){i0.simm12[11]}}, i0.simm12};
        imm20 = {{(WIDTH_ADDR-20){i1.simm20[19]}}, i1.simm20};
        d         = '0;
        d.group   = i0.group;
        d.op_type = i0.op_type;
        d.ra      = i0.ra;
        d.rb      = i0.rb;
        d.rc      = i0.rc;
        d.nop     = 1'b1;
        unique case (1'b1)
            (i0.group == GRP_IOG0): begin
                d.oper        = i0.oper;
                d.nop         = (i0.oper == OP0_BAD0)
                             || (i0.oper == OP0_BAD1);
                d.signext_imm = imm12;
            end
            (i0.group == GRP_IOG1): begin
                d.oper        = i1.oper;
                d.nop         = !((i1.oper == OP1_BTRU)
                             || (i1.oper == OP1_BFAL)
                             || (i1.oper == OP1_JMP));
                d.signext_imm = imm20;
            end
            (i0.group == GRP_IOG2): begin
                d.oper        = i0.oper;
                d.nop         = i0.oper[3] && (i0.oper != OP2_LDF16);
                d.signext_imm = imm12;
            end
            (i0.group == GRP_IOG3): begin
                d.oper        = i0.oper;
                d.nop         = i0.oper[3] && (i0.oper != OP3_STF16);
                d.signext_imm = imm12;
            end
            default: begin
                d.oper        = '0;
                d.nop         = 1'b1;
                d.signext_imm = '0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/snow64_decode_queue_if.sv
// Fetch-side and consumer-side handshake bundle of the decode queue.
// master drives fetch/consumer inputs; slave is the queue itself.
import snow64_decode_queue_pkg::*;

interface snow64_decode_queue_if #(
    parameter int DEPTH    = 4,
    parameter int WIDTH_PC = 64
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH_INSTR-1:0]       in_instr;
    logic [WIDTH_PC-1:0]          in_pc;
    logic                         flush;
    logic                         out_valid;
    logic                         out_ready;
    instr_decoder_out_t           out;
    logic [WIDTH_PC-1:0]          out_pc;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output in_valid, in_instr, in_pc, flush, out_ready,
        input  in_ready, out_valid, out, out_pc, count
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, out_ready,
        output in_ready, out_valid, out, out_pc, count
    );
endinterface

// File: rtl/snow64_decode_queue_fifo.sv
// Generic DEPTH-entry register FIFO with wrapping ptrs and occupancy count.
// The head slot drives rdata directly; storage clears to zero on reset.
import snow64_decode_queue_pkg::*;

module snow64_decode_queue_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = queue_entry_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  T              wdata,
    output T              rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/snow64_decode_queue.sv
// Decode stage: decode at entry, queue decoded record + PC, drain by valid/ready.
// SNOW64_DECODE_QUEUE_NOP_SQUASH_EN drops accepted nop words instead of queueing them.
import snow64_decode_queue_pkg::*;

module snow64_decode_queue #(
    parameter int DEPTH    = 4,
    parameter int WIDTH_PC = WIDTH_ADDR
) (
    input  logic                  clk,
    input  logic                  rst,
    snow64_decode_queue_if.slave  bus
);
    instr_decoder_out_t dec;
    queue_entry_t       wr_entry;
    queue_entry_t       head;
    logic               full;
    logic               empty;
    logic               accept;
    logic               push;
    logic               pop;

    assign dec      = decode(bus.in_instr);
    assign wr_entry = '{dec: dec, pc: bus.in_pc};

    assign accept = bus.in_valid && !full && !bus.flush;
    assign pop    = !empty && bus.out_ready && !bus.flush;

`ifdef SNOW64_DECODE_QUEUE_NOP_SQUASH_EN
    assign push = accept && !dec.nop;
`else
    assign push = accept;
`endif

    snow64_decode_queue_fifo #(
        .DEPTH (DEPTH),
        .T     (queue_entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (bus.flush),
        .wdata (wr_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (bus.count)
    );

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.out       = head.dec;
    assign bus.out_pc    = head.pc;
endmodule
